// File: rtl/rf_pkg.sv
// Shared register-file widths and the writeback queue entry format.
package rf_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_fwd_match.sv
// Forwarding search for one lookup port: scans queued entries oldest to youngest
// so the youngest matching entry ends up driving the result.
module rf_fwd_match
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  wb_entry_t              entries [DEPTH],
  input  logic [PW-1:0]          head,
  input  logic [CW-1:0]          count,
  input  logic [REG_ADDR_W-1:0]  addr,
  output logic                   hit,
  output logic [REG_DATA_W-1:0]  data
);

  logic [PW-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      // Later (younger) matches overwrite earlier ones.
      if ((CW'(i) < count) && (addr != REG_ZERO) && (entries[idx].addr == addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/rf_write_buffer.sv
// Writeback queue in front of the register file's single write port, with
// two producers (A older, B younger), in-order drain and forwarding lookups.
module rf_write_buffer
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = REG_ADDR_W,
  parameter int unsigned DW    = REG_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [AW-1:0]            a_addr,
  input  logic [DW-1:0]            a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [AW-1:0]            b_addr,
  input  logic [DW-1:0]            b_data,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_waddr,
  output logic [DW-1:0]            rf_wdata,
  input  logic [AW-1:0]            rs_addr,
  output logic                     rs_fwd_hit,
  output logic [DW-1:0]            rs_fwd_data,
  input  logic [AW-1:0]            rt_addr,
  output logic                     rt_fwd_hit,
  output logic [DW-1:0]            rt_fwd_data,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] b_slot;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          a_push;
  logic          b_push;
  logic          pop;

  // Readiness uses start-of-cycle occupancy; the same-cycle pop is not credited.
  always_comb begin
    free    = CW'(DEPTH) - count;
    a_ready = !rst && (free >= CW'(1));
    b_ready = !rst && (a_valid ? (free >= CW'(2)) : (free >= CW'(1)));
    a_push  = a_valid && a_ready && (a_addr != '0);
    b_push  = b_valid && b_ready && (b_addr != '0);
    pop     = (count != '0);
    b_slot  = a_push ? (tail + PW'(1)) : tail;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) head <= head + PW'(1);
      tail  <= tail + PW'(a_push) + PW'(b_push);
      count <= count + CW'(a_push) + CW'(b_push) - CW'(pop);
    end
  end

  // Storage needs no reset: occupancy alone defines which slots are live.
  always_ff @(posedge clk) begin
    if (a_push) mem[tail]   <= '{addr: a_addr, data: a_data};
    if (b_push) mem[b_slot] <= '{addr: b_addr, data: b_data};
  end

  always_comb begin
    rf_we    = pop;
    rf_waddr = pop ? mem[head].addr : '0;
    rf_wdata = pop ? mem[head].data : '0;
    pending  = count;
  end

  rf_fwd_match #(.DEPTH(DEPTH)) u_fwd_rs (
    .entries (mem),
    .head    (head),
    .count   (count),
    .addr    (rs_addr),
    .hit     (rs_fwd_hit),
    .data    (rs_fwd_data)
  );

  rf_fwd_match #(.DEPTH(DEPTH)) u_fwd_rt (
    .entries (mem),
    .head    (head),
    .count   (count),
    .addr    (rt_addr),
    .hit     (rt_fwd_hit),
    .data    (rt_fwd_data)
  );

endmodule
